// File: rtl/inst_fetch.sv
// Instruction fetch front-end: sequential PC generation, valid/ready requests to instruction
// memory, an in-order response buffer feeding the decoder, and redirect/flush handling.
module inst_fetch #(
    parameter int unsigned     xlen       = 32,
    parameter logic [xlen-1:0] reset_pc   = 32'h0000_0000,
    parameter int unsigned     fifo_depth = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [xlen-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [xlen-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [xlen-1:0] cur_pc,
    input  logic            inst_ready,
    output logic            fetch_err
);
    localparam int unsigned ptr_w = $clog2(fifo_depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam logic [31:0]    nop_inst  = 32'h0000_0013;
    localparam logic [cnt_w:0] depth_lim = (cnt_w + 1)'(fifo_depth);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_run   = 2'd1,
        st_flush = 2'd2,
        st_halt  = 2'd3
    } state_t;

    state_t           state_r, state_next_s;
    logic             req_valid_r, req_valid_next_s;
    logic [xlen-1:0]  req_addr_r, alt_addr_r, cur_pc_r;
    logic             alt_pend_r;
    logic [cnt_w-1:0] outstanding_r, drop_cnt_r, count_r;
    logic [31:0]      mem_r [fifo_depth];
    logic [ptr_w-1:0] rd_ptr_r, wr_ptr_r, rd_next_s;
    logic             inst_valid_r, fetch_err_r;
    logic [31:0]      inst_r, head_next_s;

    logic             accept_s, held_s, pop_s, push_s;
    logic             redir_ok_s, redir_bad_s, flush_s, room_s;
    logic [cnt_w-1:0] out_next_s, cnt_next_s, drop_new_s, drop_dec_s;

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = req_addr_r;
    assign inst_valid     = inst_valid_r;
    assign inst           = inst_r;
    assign cur_pc         = cur_pc_r;
    assign fetch_err      = fetch_err_r;

    // Next-cycle bookkeeping: counters, buffer head and FSM state
    always_comb begin
        accept_s    = req_valid_r & imem_req_ready;
        held_s      = req_valid_r & ~imem_req_ready;
        pop_s       = inst_valid_r & inst_ready;
        push_s      = imem_rsp_valid & (state_r == st_run);
        redir_ok_s  = redirect & (state_r != st_halt) & (redirect_pc[1:0] == 2'b00);
        redir_bad_s = redirect & (state_r != st_halt) & (redirect_pc[1:0] != 2'b00);
        flush_s     = redir_ok_s | redir_bad_s;
        out_next_s  = outstanding_r + cnt_w'(accept_s) - cnt_w'(imem_rsp_valid);
        if (flush_s) begin
            cnt_next_s = {cnt_w{1'b0}};
        end else begin
            cnt_next_s = count_r + cnt_w'(push_s) - cnt_w'(pop_s);
        end
        rd_next_s = rd_ptr_r + ptr_w'(pop_s);
        // A push into an otherwise drained buffer becomes the new head directly
        if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = imem_rsp_data;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
        // The still-pending bus request is in flight too; its response must be dropped
        drop_new_s = out_next_s + cnt_w'(held_s);
        if (imem_rsp_valid && (drop_cnt_r != {cnt_w{1'b0}})) begin
            drop_dec_s = drop_cnt_r - cnt_w'(1'b1);
        end else begin
            drop_dec_s = drop_cnt_r;
        end
        case (state_r)
            st_idle:  state_next_s = st_run;
            st_run:   state_next_s = st_run;
            st_flush: state_next_s = (drop_dec_s == {cnt_w{1'b0}}) ? st_run : st_flush;
            st_halt:  state_next_s = st_halt;
            default:  state_next_s = st_halt;
        endcase
        if (redir_bad_s) begin
            state_next_s = st_halt;
        end else if (redir_ok_s) begin
            state_next_s = (drop_new_s != {cnt_w{1'b0}}) ? st_flush : st_run;
        end else begin
            state_next_s = state_next_s;
        end
        room_s = ({1'b0, out_next_s} + {1'b0, cnt_next_s}) < depth_lim;
        req_valid_next_s = (held_s && (state_next_s != st_halt)) ||
                           ((state_next_s == st_run) && room_s);
    end

    // State, request channel, instruction buffer and decoder-side registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= st_idle;
            req_valid_r   <= 1'b0;
            req_addr_r    <= reset_pc;
            alt_pend_r    <= 1'b0;
            alt_addr_r    <= reset_pc;
            outstanding_r <= {cnt_w{1'b0}};
            drop_cnt_r    <= {cnt_w{1'b0}};
            count_r       <= {cnt_w{1'b0}};
            rd_ptr_r      <= {ptr_w{1'b0}};
            wr_ptr_r      <= {ptr_w{1'b0}};
            for (int i = 0; i < int'(fifo_depth); i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            inst_valid_r  <= 1'b0;
            inst_r        <= nop_inst;
            cur_pc_r      <= reset_pc;
            fetch_err_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            req_valid_r   <= req_valid_next_s;
            outstanding_r <= out_next_s;
            count_r       <= cnt_next_s;
            if (redir_ok_s) begin
                drop_cnt_r <= drop_new_s;
            end else if (redir_bad_s) begin
                drop_cnt_r <= {cnt_w{1'b0}};
            end else begin
                drop_cnt_r <= drop_dec_s;
            end
            // A redirect never disturbs a request still waiting on the bus
            if (redir_ok_s) begin
                if (held_s) begin
                    alt_pend_r <= 1'b1;
                    alt_addr_r <= redirect_pc;
                end else begin
                    alt_pend_r <= 1'b0;
                    req_addr_r <= redirect_pc;
                end
            end else if (accept_s) begin
                if (alt_pend_r) begin
                    alt_pend_r <= 1'b0;
                    req_addr_r <= alt_addr_r;
                end else begin
                    req_addr_r <= req_addr_r + xlen'(3'd4);
                end
            end
            if (flush_s) begin
                rd_ptr_r <= {ptr_w{1'b0}};
                wr_ptr_r <= {ptr_w{1'b0}};
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= imem_rsp_data;
                end
                wr_ptr_r <= wr_ptr_r + ptr_w'(push_s);
                rd_ptr_r <= rd_next_s;
            end
            inst_valid_r <= (cnt_next_s != {cnt_w{1'b0}});
            if (cnt_next_s != {cnt_w{1'b0}}) begin
                inst_r <= head_next_s;
            end
            if (flush_s) begin
                cur_pc_r <= redirect_pc;
            end else if (pop_s) begin
                cur_pc_r <= cur_pc_r + xlen'(3'd4);
            end
            fetch_err_r <= fetch_err_r | redir_bad_s;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a memory model answers accepted requests in order and a
// reference PC stream predicts every request address and every instruction handed to the decoder.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] cur_pc;
    logic        inst_ready = 1'b0;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    logic [31:0] mq[$];
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    bit          pend_flag = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    inst_fetch dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
        .cur_pc(cur_pc), .inst_ready(inst_ready), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the negedge and advance the reference stream.
    // mode 1 forces a redirect to fpc; mode 2 forces one only when a response and a pop coincide.
    task automatic step(input int p_rdy, input int p_irdy, input int p_rsp, input int p_red,
                        input int mode, input logic [31:0] fpc, output bit fired);
        logic [31:0] a;
        @(negedge clk);
        fired = (mode == 1) || ((mode == 2) && inst_valid && (mq.size() != 0));
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        inst_ready = fired || ($urandom_range(0, 99) < p_irdy);
        if ((mq.size() != 0) && ((fired && mode == 2) || ($urandom_range(0, 99) < p_rsp))) begin
            a = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data = memfn(a);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = $urandom;
        end
        redirect = fired || ($urandom_range(0, 99) < p_red);
        redirect_pc = fired ? fpc : (32'($urandom_range(0, 1023)) << 2);
        if (imem_req_valid && imem_req_ready) begin
            check_val("req_addr", imem_req_addr, exp_req);
            mq.push_back(imem_req_addr);
            if (pend_flag) begin
                exp_req = pend_addr;
                pend_flag = 1'b0;
            end else begin
                exp_req = exp_req + 32'd4;
            end
        end
        if (inst_valid && inst_ready) begin
            check_val("cur_pc", cur_pc, exp_pc);
            check_val("inst", inst, memfn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect) begin
            exp_pc = redirect_pc;
            if (imem_req_valid && !imem_req_ready) begin
                pend_flag = 1'b1;
                pend_addr = redirect_pc;
            end else begin
                exp_req = redirect_pc;
            end
        end
        check_val("outstanding_le2", 32'(mq.size() <= 2), 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check_val({pfx, "_req_addr"}, imem_req_addr, 32'h0000_0000);
        check_val({pfx, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check_val({pfx, "_inst"}, inst, 32'h0000_0013);
        check_val({pfx, "_cur_pc"}, cur_pc, 32'h0000_0000);
        check_val({pfx, "_fetch_err"}, 32'(fetch_err), 32'd0);
    endtask

    initial begin
        bit f;
        int p0;
        bit hit;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;

        // sequential fetch with an always-ready memory and decoder
        repeat (60) step(100, 100, 100, 0, 0, 32'h0, f);
        check_val("t1_progress", 32'(pops >= 30), 32'd1);

        // decoder stall: buffer fills, requests stop, nothing is lost afterwards
        repeat (10) step(100, 0, 100, 0, 0, 32'h0, f);
        check_val("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
        check_val("t2_inst_valid", 32'(inst_valid), 32'd1);
        repeat (20) step(100, 100, 100, 0, 0, 32'h0, f);

        // two requests in flight, then redirect to 0x100
        repeat (6) step(100, 100, 0, 0, 0, 32'h0, f);
        check_val("t3_two_out", 32'(mq.size()), 32'd2);
        check_val("t3_req_stall", 32'(imem_req_valid), 32'd0);
        step(100, 100, 0, 0, 1, 32'h0000_0100, f);
        p0 = pops;
        repeat (30) step(100, 100, 100, 0, 0, 32'h0, f);
        check_val("t3_resumed", 32'(pops > p0), 32'd1);

        // redirect coinciding with a response and a pop
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(100, 100, 100, 0, 2, 32'h0000_0200, f);
            hit = f;
        end
        check_val("t4_fired", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        check_val("t4_fifo_empty", 32'(inst_valid), 32'd0);
        repeat (20) step(100, 100, 100, 0, 0, 32'h0, f);

        // random traffic with random aligned redirects
        p0 = pops;
        repeat (3000) step(70, 70, 60, 3, 0, 32'h0, f);
        check_val("rand_progress", 32'(pops - p0 > 200), 32'd1);
        repeat (20) step(100, 100, 100, 0, 0, 32'h0, f);

        // address wrap-around at the top of the address space
        step(100, 100, 100, 0, 1, 32'hFFFF_FFF8, f);
        repeat (20) step(100, 100, 100, 0, 0, 32'h0, f);
        check_val("t7_wrapped", 32'(exp_req < 32'h0000_0100), 32'd1);

        // asynchronous reset in the middle of a stalled burst
        repeat (5) step(100, 100, 100, 0, 0, 32'h0, f);
        repeat (3) step(0, 100, 100, 0, 0, 32'h0, f);
        #2;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect = 1'b0;
        #1;
        check_reset_values("t6");
        mq.delete();
        exp_req = 32'h0;
        exp_pc = 32'h0;
        pend_flag = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        p0 = pops;
        repeat (20) step(100, 100, 100, 0, 0, 32'h0, f);
        check_val("t6_restart", 32'(pops > p0), 32'd1);

        // misaligned redirect halts fetch until reset
        step(100, 100, 100, 0, 1, 32'h0000_0102, f);
        for (int i = 0; i < 10; i++) begin
            step(100, 100, 100, 0, 0, 32'h0, f);
            check_val("t5_req_valid", 32'(imem_req_valid), 32'd0);
            check_val("t5_inst_valid", 32'(inst_valid), 32'd0);
            check_val("t5_fetch_err", 32'(fetch_err), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
